// File: rtl/led_frame_shifter.sv
// led_frame_shifter
// Serialises one frame of LED colour words, MSB first, one bit per bit_req
// handshake from an external bit-timing engine. Each LED word is built on the
// fly from the colour inputs latched at frame start, according to the mode:
// uniform, gradient (base + index*step), chase (one lit LED per frame) or off.
//
// Build option: define LED_FRAME_SHIFTER_RGBW_EN to add a fourth (W) channel.
// W is then transmitted last and the word grows from 24 to 32 bits. Without
// the macro the channel inputs carry only G, R and B.
module led_frame_shifter #(
  parameter int NUM_LEDS = 8,
  parameter int CW       = 4,
`ifdef LED_FRAME_SHIFTER_RGBW_EN
  localparam int NCH     = 4,
`else
  localparam int NCH     = 3,
`endif
  localparam int LW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              bit_req,
  input  logic [1:0]        mode,
  input  logic [NCH*CW-1:0] base_color,
  input  logic [NCH*CW-1:0] step,
  output logic              current_bit,
  output logic              bit_valid,
  output logic [LW-1:0]     led_index,
  output logic              busy,
  output logic              frame_done
);

  localparam int WW = 8 * NCH;
  localparam int BW = $clog2(WW);

  localparam logic [LW-1:0] LAST_LED = LW'(NUM_LEDS - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WW - 1);

  localparam logic [1:0] MODE_UNIFORM  = 2'd0;
  localparam logic [1:0] MODE_GRADIENT = 2'd1;
  localparam logic [1:0] MODE_CHASE    = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  logic [WW-1:0]     shiftReg;
  logic [BW-1:0]     bitCnt;
  logic [LW-1:0]     phase;
  logic [1:0]        modeLat;
  logic [NCH*CW-1:0] baseLat;
  logic [NCH*CW-1:0] stepLat;
  logic [WW-1:0]     nextWord;

  // Value of one channel for the LED at idx. Gradient arithmetic is done in
  // CW bits so that it wraps modulo 2^CW without any extra masking.
  function automatic logic [CW-1:0] chanValue(
    input logic [1:0]    m,
    input logic [CW-1:0] b,
    input logic [CW-1:0] s,
    input logic [LW-1:0] idx,
    input logic [LW-1:0] ph
  );
    logic [CW-1:0] idxC;
    logic [CW-1:0] v;
    idxC = CW'(idx);
    case (m)
      MODE_UNIFORM:  v = b;
      MODE_GRADIENT: v = b + idxC * s;
      MODE_CHASE:    v = (idx == ph) ? b : '0;
      default:       v = '0;
    endcase
    return v;
  endfunction

  // Full LED word: channel fields and word bytes share the same ordering
  // (G in the top field/byte, W in the bottom when present), and each value
  // sits in the upper CW bits of its byte.
  function automatic logic [WW-1:0] buildWord(
    input logic [1:0]        m,
    input logic [NCH*CW-1:0] b,
    input logic [NCH*CW-1:0] s,
    input logic [LW-1:0]     idx,
    input logic [LW-1:0]     ph
  );
    logic [WW-1:0] w;
    logic [CW-1:0] v;
    w = '0;
    for (int c = 0; c < NCH; c++) begin
      v = chanValue(m, b[c*CW +: CW], s[c*CW +: CW], idx, ph);
      w[c*8 +: 8] = 8'(v) << (8 - CW);
    end
    return w;
  endfunction

  // Word for the LED about to be loaded, from the frame's latched settings.
  always_comb begin
    nextWord = buildWord(modeLat, baseLat, stepLat, led_index, phase);
  end

  assign current_bit = shiftReg[WW-1];

  // Frame sequencer: IDLE -> LOAD -> SHIFT (per LED) -> DONE -> IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shiftReg   <= '0;
      bitCnt     <= '0;
      led_index  <= '0;
      phase      <= '0;
      modeLat    <= '0;
      baseLat    <= '0;
      stepLat    <= '0;
      bit_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (start) begin
            modeLat   <= mode;
            baseLat   <= base_color;
            stepLat   <= step;
            led_index <= '0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          shiftReg  <= nextWord;
          bitCnt    <= '0;
          bit_valid <= 1'b1;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (bit_req) begin
            shiftReg <= {shiftReg[WW-2:0], shiftReg[WW-1]};
            if (bitCnt == LAST_BIT) begin
              bitCnt    <= '0;
              bit_valid <= 1'b0;
              if (led_index == LAST_LED) begin
                frame_done <= 1'b1;
                state      <= DONE;
              end else begin
                led_index <= led_index + 1'b1;
                state     <= LOAD;
              end
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end
        end
        DONE: begin
          // Clear the word so current_bit idles low between frames.
          shiftReg   <= '0;
          frame_done <= 1'b0;
          busy       <= 1'b0;
          phase      <= (phase == LAST_LED) ? '0 : phase + 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_shifter.sv
// tb_led_frame_shifter
// Randomised frame bench for led_frame_shifter (NUM_LEDS=4, CW=4, RGB build).
// Expected LED words come from the colour rules applied with plain integer
// arithmetic; received bits are reassembled per LED and compared.
module tb_led_frame_shifter;

  localparam int NL    = 4;
  localparam int CW    = 4;
  localparam int NCH   = 3;
  localparam int WW    = 8 * NCH;
  localparam int LW    = 2;
  localparam int TOTAL = NL * WW;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              bitReq = 1'b0;
  logic [1:0]        mode = '0;
  logic [NCH*CW-1:0] baseColor = '0;
  logic [NCH*CW-1:0] stepVal = '0;
  logic              currentBit;
  logic              bitValid;
  logic [LW-1:0]     ledIndex;
  logic              busy;
  logic              frameDone;

  int nCompared   = 0;
  int nMismatched = 0;
  int modelPhase  = 0;

  always #5 clk = ~clk;

  led_frame_shifter #(.NUM_LEDS(NL), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bit_req    (bitReq),
    .mode       (mode),
    .base_color (baseColor),
    .step       (stepVal),
    .current_bit(currentBit),
    .bit_valid  (bitValid),
    .led_index  (ledIndex),
    .busy       (busy),
    .frame_done (frameDone)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected word for one LED, straight from the colour rules.
  function automatic logic [31:0] modelWord(input int m, input logic [11:0] b,
                                            input logic [11:0] s, input int led, input int ph);
    logic [31:0] w;
    int bv;
    int sv;
    int v;
    w = 0;
    for (int c = 0; c < NCH; c++) begin
      bv = int'(b[(NCH-1-c)*CW +: CW]);
      sv = int'(s[(NCH-1-c)*CW +: CW]);
      case (m)
        0:       v = bv;
        1:       v = (bv + led * sv) % 16;
        2:       v = (led == ph) ? bv : 0;
        default: v = 0;
      endcase
      w = (w << 8) | 32'(v * 16);
    end
    return w;
  endfunction

  task automatic scramble();
    mode      = 2'($urandom);
    baseColor = 12'($urandom);
    stepVal   = 12'($urandom);
    start     = 1'($urandom);
  endtask

  // One frame: m/b/s are the settings latched at start; prob is the bit_req
  // percentage; abortAt >= 0 pulls reset after that many bits.
  task automatic runFrame(input int m, input logic [11:0] b, input logic [11:0] s,
                          input int prob, input int abortAt);
    logic [WW-1:0] got [NL];
    logic [31:0]   expW;
    int consumed;
    int cyc;
    int ph;
    bit doneSeen;
    bit expValid;
    consumed = 0;
    cyc      = 0;
    doneSeen = 0;
    ph       = modelPhase;
    for (int i = 0; i < NL; i++) got[i] = '0;

    @(negedge clk);
    mode = m[1:0]; baseColor = b; stepVal = s; start = 1'b1; bitReq = 1'b1;
    @(negedge clk);
    check("load_busy", 32'(busy), 1);
    check("load_valid", 32'(bitValid), 0);
    scramble();
    bitReq   = 1'($urandom);
    expValid = 1'b1;

    while (!doneSeen && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (abortAt >= 0 && consumed == abortAt) begin
        start = 1'b0; bitReq = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(bitValid), 0);
        check("rst_bit", 32'(currentBit), 0);
        check("rst_index", 32'(ledIndex), 0);
        check("rst_done", 32'(frameDone), 0);
        @(negedge clk);
        reset = 1'b1;
        modelPhase = 0;
        repeat (3) begin
          @(negedge clk);
          check("rst_idle", 32'(busy), 0);
        end
        return;
      end
      check("frame_done", 32'(frameDone), 32'(consumed == TOTAL));
      if (consumed == TOTAL) begin
        doneSeen = 1'b1;
        check("done_busy", 32'(busy), 1);
      end else begin
        check("bit_valid", 32'(bitValid), 32'(expValid));
        if (bitValid) begin
          check("led_index", 32'(ledIndex), 32'(consumed / WW));
          bitReq = ($urandom_range(99, 0) < 32'(prob));
          if (bitReq) begin
            got[consumed / WW][WW-1-(consumed % WW)] = currentBit;
            consumed++;
            expValid = (consumed % WW) != 0;
          end
        end else begin
          bitReq   = 1'($urandom);
          expValid = 1'b1;
        end
      end
      mode = 2'($urandom); baseColor = 12'($urandom); stepVal = 12'($urandom);
      start = 1'($urandom);
    end
    if (!doneSeen) check("timeout", 0, 1);

    // start presented while in DONE must not launch a frame
    start = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_valid", 32'(bitValid), 0);
    start = 1'b0;
    @(negedge clk);
    check("idle_stay", 32'(busy), 0);
    modelPhase = (modelPhase + 1) % NL;

    for (int led = 0; led < NL; led++) begin
      expW = modelWord(m, b, s, led, ph);
      check($sformatf("word_m%0d_led%0d", m, led), 32'(got[led]), expW);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_valid", 32'(bitValid), 0);
    check("reset_done", 32'(frameDone), 0);
    check("reset_bit", 32'(currentBit), 0);
    check("reset_index", 32'(ledIndex), 0);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_spont_start", 32'(busy), 0);
    end

    runFrame(0, 12'hF00, 12'h000, 100, -1);
    runFrame(1, 12'h123, 12'h111, 100, -1);
    runFrame(1, 12'hF00, 12'h100, 60, -1);
    for (int f = 0; f < 5; f++) runFrame(2, 12'hFFF, 12'h000, 70, -1);
    runFrame(3, 12'hABC, 12'h123, 50, -1);
    runFrame(2, 12'hFFF, 12'h000, 100, -1);
    runFrame(2, 12'hFFF, 12'h000, 80, 40);
    runFrame(2, 12'hFFF, 12'h000, 100, -1);
    for (int f = 0; f < 10; f++)
      runFrame(int'($urandom_range(3, 0)), 12'($urandom), 12'($urandom),
               int'($urandom_range(100, 20)), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
